// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side memory ports and the byte-wide RAM port served by mem_arbiter.
// The slave modport is the arbiter's view; master is the core plus RAM side.
interface mem_arbiter_if #(
    parameter int R_PORT     = 2,
    parameter int W_PORT     = 1,
    parameter int DATA_L     = 32,
    parameter int ADDR_L     = 32,
    parameter int MEM_ADDR_L = 17
);
    logic [R_PORT*DATA_L-1:0] co_din;
    logic [W_PORT*DATA_L-1:0] co_dout;
    logic [R_PORT*ADDR_L-1:0] co_raddr;
    logic [W_PORT*ADDR_L-1:0] co_waddr;
    logic [R_PORT-1:0]        co_re;
    logic [W_PORT-1:0]        co_we;
    logic [R_PORT*2-1:0]      co_rlen;
    logic [W_PORT*2-1:0]      co_wlen;
    logic [R_PORT-1:0]        co_rack;
    logic [W_PORT-1:0]        co_wack;
    logic [MEM_ADDR_L-1:0]    mem_addr;
    logic [7:0]               mem_dout;
    logic [7:0]               mem_din;
    logic                     mem_we;

    modport slave (
        output co_din, co_rack, co_wack, mem_addr, mem_dout, mem_we,
        input  co_dout, co_raddr, co_waddr, co_re, co_we, co_rlen, co_wlen, mem_din
    );

    modport master (
        input  co_din, co_rack, co_wack, mem_addr, mem_dout, mem_we,
        output co_dout, co_raddr, co_waddr, co_re, co_we, co_rlen, co_wlen, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises two core read ports and one write port onto a byte-wide synchronous RAM,
// splitting and assembling 1-4 byte little-endian accesses with registered one-cycle acks.
module mem_arbiter #(
    parameter int R_PORT     = 2,
    parameter int W_PORT     = 1,
    parameter int DATA_L     = 32,
    parameter int ADDR_L     = 32,
    parameter int MEM_ADDR_L = 17
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    localparam int AZ = MEM_ADDR_L - 3;

    state_t                state_q, state_d;
    logic [MEM_ADDR_L-1:0] base_q, base_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_L-1:0]     wdata_q, wdata_d;
    logic [DATA_L-1:0]     rbuf_q, rbuf_d;
    logic                  port_q, port_d;
    logic                  lastRd_q, lastRd_d;
    logic [MEM_ADDR_L-1:0] maddr_q, maddr_d;
    logic [7:0]            mdout_q, mdout_d;
    logic                  mwe_q, mwe_d;
    logic [DATA_L-1:0]     din0_q, din0_d;
    logic [DATA_L-1:0]     din1_q, din1_d;
    logic [R_PORT-1:0]     rack_q, rack_d;
    logic [W_PORT-1:0]     wack_q, wack_d;

    logic [2:0]            nextCnt;
    logic [1:0]            byteSel;
    logic                  rdPick;
    logic                  unusedAddrBits;

    assign bus.co_din   = {din1_q, din0_q};
    assign bus.co_rack  = rack_q;
    assign bus.co_wack  = wack_q;
    assign bus.mem_addr = maddr_q;
    assign bus.mem_dout = mdout_q;
    assign bus.mem_we   = mwe_q;

    assign unusedAddrBits = ^{bus.co_raddr[ADDR_L-1:MEM_ADDR_L],
                              bus.co_raddr[2*ADDR_L-1:ADDR_L+MEM_ADDR_L],
                              bus.co_waddr[ADDR_L-1:MEM_ADDR_L]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            port_q   <= 1'b0;
            lastRd_q <= 1'b0;
            maddr_q  <= '0;
            mdout_q  <= '0;
            mwe_q    <= 1'b0;
            din0_q   <= '0;
            din1_q   <= '0;
            rack_q   <= '0;
            wack_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            port_q   <= port_d;
            lastRd_q <= lastRd_d;
            maddr_q  <= maddr_d;
            mdout_q  <= mdout_d;
            mwe_q    <= mwe_d;
            din0_q   <= din0_d;
            din1_q   <= din1_d;
            rack_q   <= rack_d;
            wack_q   <= wack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        port_d   = port_q;
        lastRd_d = lastRd_q;
        maddr_d  = maddr_q;
        mdout_d  = mdout_q;
        mwe_d    = 1'b0;
        din0_d   = din0_q;
        din1_d   = din1_q;
        rack_d   = '0;
        wack_d   = '0;
        nextCnt  = cnt_q + 3'd1;
        byteSel  = cnt_q[1:0] - 2'd1;
        // lastRd_q resets to 0 so port 1 wins the first two-way contest
        rdPick   = (&bus.co_re) ? ~lastRd_q : bus.co_re[1];

        case (state_q)
            IDLE: begin
                if (bus.co_we[0]) begin
                    state_d = WR;
                    base_d  = bus.co_waddr[MEM_ADDR_L-1:0];
                    len_d   = {1'b0, bus.co_wlen[1:0]} + 3'd1;
                    wdata_d = bus.co_dout[DATA_L-1:0];
                    cnt_d   = '0;
                    maddr_d = bus.co_waddr[MEM_ADDR_L-1:0];
                    mdout_d = bus.co_dout[7:0];
                    mwe_d   = 1'b1;
                end else if (|bus.co_re) begin
                    state_d  = RD;
                    port_d   = rdPick;
                    lastRd_d = rdPick;
                    base_d   = rdPick ? bus.co_raddr[ADDR_L +: MEM_ADDR_L]
                                      : bus.co_raddr[MEM_ADDR_L-1:0];
                    len_d    = {1'b0, (rdPick ? bus.co_rlen[3:2] : bus.co_rlen[1:0])} + 3'd1;
                    cnt_d    = '0;
                    rbuf_d   = '0;
                    maddr_d  = base_d;
                end
            end
            RD: begin
                // mem_din lags the address by one cycle, so cycle cnt delivers byte cnt-1
                if (cnt_q != 3'd0) begin
                    rbuf_d[{byteSel, 3'b000} +: 8] = bus.mem_din;
                end
                if (cnt_q == len_q) begin
                    state_d        = ACK;
                    rack_d[port_q] = 1'b1;
                    if (port_q) begin
                        din1_d = rbuf_d;
                    end else begin
                        din0_d = rbuf_d;
                    end
                end else begin
                    cnt_d = nextCnt;
                    if (nextCnt < len_q) begin
                        maddr_d = base_q + {{AZ{1'b0}}, nextCnt};
                    end
                end
            end
            WR: begin
                if (nextCnt < len_q) begin
                    cnt_d   = nextCnt;
                    maddr_d = base_q + {{AZ{1'b0}}, nextCnt};
                    mdout_d = wdata_q[{nextCnt[1:0], 3'b000} +: 8];
                    mwe_d   = 1'b1;
                end else begin
                    state_d   = ACK;
                    wack_d[0] = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model predicts every cycle's
// outputs from the arbitration and latency rules, and directed tests pin literal results.
module tb_mem_arbiter;
    localparam int MEM_SIZE = 131072;
    localparam int KRD      = 1;
    localparam int KWR      = 2;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.R_PORT(2), .W_PORT(1), .DATA_L(32), .ADDR_L(32), .MEM_ADDR_L(17)) bus ();

    mem_arbiter #(.R_PORT(2), .W_PORT(1), .DATA_L(32), .ADDR_L(32), .MEM_ADDR_L(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int edgeCnt     = 0;

    logic [7:0]  ram [0:MEM_SIZE-1];
    logic        bdWe = 1'b0;
    logic [16:0] bdAddr = '0;
    logic [7:0]  bdData = '0;

    // Byte-wide synchronous RAM with one-cycle read latency, plus a backdoor preload port
    always @(posedge clk) begin
        if (bdWe) ram[bdAddr] <= bdData;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_addr];
    end

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Model state: the transaction granted at edge txEdge and its predicted effects
    int          txKind = 0;
    int          txPort = 0;
    int          txLen = 0;
    int          txEdge = 0;
    int          txBase = 0;
    int          freeEdge = 0;
    int          lastRead = 0;
    logic [31:0] txData = '0;
    logic [31:0] txValue = '0;
    logic [31:0] expDin [2];
    logic [7:0]  modelRam [0:MEM_SIZE-1];
    logic [24:0] wrLog [$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    initial begin : model
        expDin[0] = '0;
        expDin[1] = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                txKind    = 0;
                lastRead  = 0;
                freeEdge  = 0;
                expDin[0] = '0;
                expDin[1] = '0;
            end else begin
                if (bdWe) modelRam[bdAddr] = bdData;
                if (txKind == KRD && edgeCnt == txEdge + txLen + 1) expDin[txPort] = txValue;
                if (edgeCnt >= freeEdge) begin
                    txKind = 0;
                    if (bus.co_we[0]) begin
                        txKind = KWR;
                        txEdge = edgeCnt;
                        txBase = int'(bus.co_waddr[16:0]);
                        txLen  = int'(bus.co_wlen) + 1;
                        txData = bus.co_dout;
                        for (int k = 0; k < txLen; k++) modelRam[(txBase + k) % MEM_SIZE] = txData[8*k +: 8];
                        freeEdge = edgeCnt + txLen + 2;
                    end else if (bus.co_re != 2'b00) begin
                        if (bus.co_re == 2'b11) txPort = 1 - lastRead;
                        else txPort = bus.co_re[1] ? 1 : 0;
                        lastRead = txPort;
                        txKind   = KRD;
                        txEdge   = edgeCnt;
                        txBase   = int'(bus.co_raddr[txPort*32 +: 17]);
                        txLen    = int'(bus.co_rlen[txPort*2 +: 2]) + 1;
                        txValue  = '0;
                        for (int k = 0; k < txLen; k++)
                            txValue = txValue | (32'(modelRam[(txBase + k) % MEM_SIZE]) << (8*k));
                        freeEdge = edgeCnt + txLen + 3;
                    end
                end
            end
        end
    end

    initial begin : compare
        int   off;
        logic expWe;
        logic expWack;
        logic [1:0] expRack;
        forever begin
            @(negedge clk);
            off     = edgeCnt - txEdge;
            expWe   = (txKind == KWR && off >= 1 && off <= txLen);
            expWack = (txKind == KWR && off == txLen + 1);
            expRack = (txKind == KRD && off == txLen + 2) ? (2'b01 << txPort) : 2'b00;
            checkOutput("mem_we", bus.mem_we, expWe);
            checkOutput("co_wack", bus.co_wack, expWack);
            checkOutput("co_rack", bus.co_rack, expRack);
            checkOutput("co_din", bus.co_din, {expDin[1], expDin[0]});
            checkOutput("oneAck", ($countones({bus.co_rack, bus.co_wack}) <= 1), 1);
            if (txKind != 0 && off >= 1 && off <= txLen) begin
                checkOutput("mem_addr", bus.mem_addr, (txBase + off - 1) % MEM_SIZE);
                if (txKind == KWR) checkOutput("mem_dout", bus.mem_dout, txData[8*(off-1) +: 8]);
            end
            if (bus.mem_we) wrLog.push_back({bus.mem_addr, bus.mem_dout});
        end
    end

    task automatic preload(input logic [16:0] addr, input logic [7:0] data);
        @(negedge clk);
        bdWe   = 1'b1;
        bdAddr = addr;
        bdData = data;
        @(negedge clk);
        bdWe   = 1'b0;
    endtask

    task automatic applyStimulus(input int kind, input int port, input logic [31:0] addr,
                                 input logic [1:0] len, input logic [31:0] data);
        @(negedge clk);
        if (kind == KWR) begin
            bus.co_we    = 1'b1;
            bus.co_waddr = addr;
            bus.co_wlen  = len;
            bus.co_dout  = data;
        end else begin
            bus.co_re[port]             = 1'b1;
            bus.co_raddr[port*32 +: 32] = addr;
            bus.co_rlen[port*2 +: 2]    = len;
        end
    endtask

    task automatic waitAck(input int which, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((which == 2) ? bus.co_wack[0] : bus.co_rack[which[0]]) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL ackTimeout: got no ack on %0d, expected one within 40 cycles", which);
        end
    endtask

    task automatic runTxn(input int kind, input int port, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] data, output int lat);
        applyStimulus(kind, port, addr, len, data);
        waitAck((kind == KWR) ? 2 : port, lat);
        if (kind == KWR) bus.co_we = 1'b0;
        else bus.co_re[port] = 1'b0;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected end before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int lat;
        int startIdx;
        int order [$];
        rst          = 1'b1;
        bus.co_re    = '0;
        bus.co_we    = '0;
        bus.co_raddr = '0;
        bus.co_waddr = '0;
        bus.co_rlen  = '0;
        bus.co_wlen  = '0;
        bus.co_dout  = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetMemWe", bus.mem_we, 0);
        checkOutput("resetMemAddr", bus.mem_addr, 0);
        checkOutput("resetMemDout", bus.mem_dout, 0);
        checkOutput("resetCoDin", bus.co_din, 0);
        checkOutput("resetAcks", {bus.co_rack, bus.co_wack}, 0);
        rst = 1'b1;

        preload(17'h00100, 8'h11);
        preload(17'h00101, 8'h22);
        preload(17'h00102, 8'h33);
        preload(17'h00103, 8'h44);
        preload(17'h00007, 8'hA5);
        preload(17'h1FFFF, 8'hBE);
        preload(17'h00000, 8'hEF);

        $display("[TB] port 0 word read");
        runTxn(KRD, 0, 32'h0000_0100, 2'd3, 32'h0, lat);
        checkOutput("p0WordLat", lat, 6);
        checkOutput("p0WordData", bus.co_din[31:0], 32'h4433_2211);
        checkOutput("p0WordOther", bus.co_din[63:32], 32'h0);

        $display("[TB] port 1 byte and wrapping half reads");
        runTxn(KRD, 1, 32'hABC0_0007, 2'd0, 32'h0, lat);
        checkOutput("p1ByteLat", lat, 3);
        checkOutput("p1ByteData", bus.co_din[63:32], 32'h0000_00A5);
        checkOutput("p1ByteOther", bus.co_din[31:0], 32'h4433_2211);
        runTxn(KRD, 1, 32'h0001_FFFF, 2'd1, 32'h0, lat);
        checkOutput("p1HalfLat", lat, 4);
        checkOutput("p1HalfWrap", bus.co_din[63:32], 32'h0000_EFBE);

        $display("[TB] word write and readback");
        startIdx = wrLog.size();
        runTxn(KWR, 0, 32'h0000_0020, 2'd3, 32'hDEAD_BEEF, lat);
        checkOutput("wrWordLat", lat, 5);
        checkOutput("wrByteCount", wrLog.size() - startIdx, 4);
        checkOutput("wrByte0", wrLog[startIdx],     {17'h00020, 8'hEF});
        checkOutput("wrByte1", wrLog[startIdx + 1], {17'h00021, 8'hBE});
        checkOutput("wrByte2", wrLog[startIdx + 2], {17'h00022, 8'hAD});
        checkOutput("wrByte3", wrLog[startIdx + 3], {17'h00023, 8'hDE});
        runTxn(KRD, 1, 32'h0000_0020, 2'd3, 32'h0, lat);
        checkOutput("readbackLat", lat, 6);
        checkOutput("readbackData", bus.co_din[63:32], 32'hDEAD_BEEF);

        $display("[TB] simultaneous requests after reset");
        resetPulse();
        @(negedge clk);
        bus.co_we    = 1'b1;
        bus.co_waddr = 32'h0000_0300;
        bus.co_wlen  = 2'd0;
        bus.co_dout  = 32'h0000_00C3;
        bus.co_raddr = {32'h0000_0007, 32'h0000_0100};
        bus.co_rlen  = {2'd0, 2'd3};
        bus.co_re    = 2'b11;
        for (int i = 0; i < 80 && (bus.co_we[0] || bus.co_re != 2'b00); i++) begin
            @(negedge clk);
            if (bus.co_wack[0]) begin
                order.push_back(2);
                bus.co_we = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (bus.co_rack[p]) begin
                    order.push_back(p);
                    bus.co_re[p] = 1'b0;
                end
            end
        end
        bus.co_we = 1'b0;
        bus.co_re = 2'b00;
        checkOutput("simulCount", order.size(), 3);
        checkOutput("simulFirst", order[0], 2);
        checkOutput("simulSecond", order[1], 1);
        checkOutput("simulThird", order[2], 0);
        checkOutput("simulData", bus.co_din, {32'h0000_00A5, 32'h4433_2211});

        $display("[TB] back-to-back read contention");
        order.delete();
        @(negedge clk);
        bus.co_raddr = {32'h0000_0007, 32'h0000_0100};
        bus.co_rlen  = {2'd0, 2'd0};
        bus.co_re    = 2'b11;
        for (int i = 0; i < 200 && order.size() < 6; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (bus.co_rack[p]) begin
                    order.push_back(p);
                    bus.co_re[p] = 1'b0;
                end else if (!bus.co_re[p]) begin
                    bus.co_re[p] = 1'b1;
                end
            end
        end
        bus.co_re = 2'b00;
        checkOutput("rrCount", order.size(), 6);
        for (int i = 0; i < 6; i++) checkOutput("rrOrder", order[i], (i % 2 == 0) ? 1 : 0);
        checkOutput("rrData", bus.co_din, {32'h0000_00A5, 32'h0000_0011});

        $display("[TB] reset during a word read");
        applyStimulus(KRD, 0, 32'h0000_0100, 2'd3, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midResetMemWe", bus.mem_we, 0);
        checkOutput("midResetRack", bus.co_rack, 0);
        checkOutput("midResetCoDin", bus.co_din, 0);
        @(negedge clk);
        bus.co_re = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        runTxn(KRD, 0, 32'h0000_0100, 2'd3, 32'h0, lat);
        checkOutput("postResetLat", lat, 6);
        checkOutput("postResetData", bus.co_din, {32'h0, 32'h4433_2211});
        runTxn(KRD, 1, 32'h0000_0020, 2'd3, 32'h0, lat);
        checkOutput("postResetP1", bus.co_din[63:32], 32'hDEAD_BEEF);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
